// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared state encoding and helpers for arbitro_rr
package arbitro_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVO = 2'b01,
    PAUSA  = 2'b10,
    ERROR  = 2'b11
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_busca.sv
// rtl/rr_busca.sv - wrapped first-non-empty search starting at ptr
// ARB_FIXED_PRIO_EN selects a plain lowest-index search that ignores ptr.
module rr_busca
  import arbitro_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  empty,
  input  logic [SW-1:0] ptr,
  output logic          hit,
  output logic [SW-1:0] idx
);

  int w_j;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    w_j = 0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        hit = 1'b1;
        idx = SW'(i);
      end
    end
`else
    // Walk from the farthest offset back to ptr so the nearest candidate wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(ptr) + k) % N;
      if (!empty[w_j]) begin
        hit = 1'b1;
        idx = SW'(w_j);
      end
    end
`endif
  end

endmodule

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - round-robin arbiter feeding one destination FIFO from N sources
// ARB_FIXED_PRIO_EN switches to fixed lowest-index priority (no ptr register).
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [N-1:0]           empty,
  input  logic [N*WIDTH-1:0]     data_in,
  input  logic                   almost_full,
  input  logic                   full,
  output logic [N-1:0]           pop,
  output logic                   push,
  output logic [WIDTH-1:0]       data_out,
  output logic [clog2(N)-1:0]    sel,
  output logic                   idle,
  output logic                   continuar,
  output logic                   pausa,
  output logic                   error_full
);

  localparam int SW = clog2(N);

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_sel;
  logic            r_push;
  logic            w_hit;
  logic [SW-1:0]   w_idx;
  logic [SW-1:0]   w_ptr;
  logic            w_grant;

`ifdef ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [SW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_idx == SW'(N - 1)) ? '0 : w_idx + SW'(1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  rr_busca #(.N(N), .SW(SW)) u_busca (
    .empty (empty),
    .ptr   (w_ptr),
    .hit   (w_hit),
    .idx   (w_idx)
  );

  assign w_grant = (r_state == ACTIVO) && !almost_full && w_hit;
  assign pop     = w_grant ? ({{(N - 1){1'b0}}, 1'b1} << w_idx) : '0;

  always_comb begin
    w_next = r_state;
    if (r_state == ERROR) begin
      w_next = ERROR;
    end else if (r_state != IDLE && r_push && full) begin
      w_next = ERROR;
    end else begin
      case (r_state)
        IDLE:    if (iniciar) w_next = ACTIVO;
        ACTIVO:  if (almost_full) w_next = PAUSA;
        PAUSA:   if (!almost_full && !full) w_next = ACTIVO;
        default: w_next = r_state;
      endcase
    end
  end

  // A pending push is deliberately dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_push  <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      r_push  <= w_grant;
      if (w_grant) r_sel <= w_idx;
    end
  end

  assign push       = r_push;
  assign sel        = r_sel;
  assign data_out   = r_push ? data_in[r_sel*WIDTH +: WIDTH] : '0;
  assign idle       = (r_state == IDLE);
  assign continuar  = (r_state == ACTIVO);
  assign pausa      = (r_state == PAUSA);
  assign error_full = (r_state == ERROR);

endmodule
